// File: rtl/minesweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_pkg
// Purpose  : Shared definitions for the minesweeper game controller:
//            FSM state encoding, default board geometry and the
//            row/column to cell-index helper.
// Revision : 1.0 - initial release
// ============================================================================
package minesweeper_pkg;

    localparam int ROWS_DEFAULT = 8;
    localparam int COLS_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_REVEAL = 3'd3,
        ST_LOST   = 3'd4,
        ST_WON    = 3'd5
    } state_t;

    // Cell index of (row, col); bit 0 of every map is the top-left cell.
    function automatic int cell_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_ctrl
// Purpose  : Cursor row/column registers, move decode with edge handling and
//            one-hot position map decode.
// Config   : WRAP_CURSOR_EN defined -> cursor wraps at board edges,
//            otherwise it clamps (a blocked move changes nothing).
// Ports    : clk, reset      clock, async active-high reset
//            home            return cursor to (0,0)
//            move_en         moves are accepted this cycle
//            mv_up/down/left/right  move pulses, priority up>down>left>right
//            pos_map         one-hot cursor position
//            cur_idx         cursor cell index
//            pos_change      the pending update will move the cursor
// Revision : 1.0 - initial release
// ============================================================================
module cursor_ctrl
    import minesweeper_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT,
    localparam int N  = ROWS * COLS,
    localparam int IW = $clog2(N),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          home,
    input  logic          move_en,
    input  logic          mv_up,
    input  logic          mv_down,
    input  logic          mv_left,
    input  logic          mv_right,
    output logic [N-1:0]  pos_map,
    output logic [IW-1:0] cur_idx,
    output logic          pos_change
);

    logic [RW-1:0] r_row, w_row_nx;
    logic [CW-1:0] r_col, w_col_nx;

    always_comb begin
        w_row_nx = r_row;
        w_col_nx = r_col;
        if (home) begin
            w_row_nx = '0;
            w_col_nx = '0;
        end else if (move_en) begin
            if (mv_up) begin
                if (r_row != '0) w_row_nx = r_row - 1'b1;
`ifdef WRAP_CURSOR_EN
                else             w_row_nx = RW'(ROWS - 1);
`endif
            end else if (mv_down) begin
                if (r_row != RW'(ROWS - 1)) w_row_nx = r_row + 1'b1;
`ifdef WRAP_CURSOR_EN
                else                        w_row_nx = '0;
`endif
            end else if (mv_left) begin
                if (r_col != '0) w_col_nx = r_col - 1'b1;
`ifdef WRAP_CURSOR_EN
                else             w_col_nx = CW'(COLS - 1);
`endif
            end else if (mv_right) begin
                if (r_col != CW'(COLS - 1)) w_col_nx = r_col + 1'b1;
`ifdef WRAP_CURSOR_EN
                else                        w_col_nx = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_row <= w_row_nx;
            r_col <= w_col_nx;
        end
    end

    // Lets the top raise redraw only for moves that actually land somewhere new.
    assign pos_change = (w_row_nx != r_row) || (w_col_nx != r_col);
    assign cur_idx    = IW'(cell_idx(int'(r_row), int'(r_col), COLS));

    always_comb begin
        pos_map          = '0;
        pos_map[cur_idx] = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Minesweeper game sequencer. Owns flag/step/cursor maps, runs the
//            IDLE/PLAY/CHECK/REVEAL/LOST/WON state machine and flags redraws.
// Config   : WRAP_CURSOR_EN (see cursor_ctrl) selects wrap vs clamp cursor.
// Ports    : clk, reset                 clock, async active-high reset
//            start, step_req, flag_req  1-cycle action pulses
//            mv_up/down/left/right      1-cycle cursor move pulses
//            mine_map                   mine locations
//            flag_map/step_map/pos_map  board maps for the renderer
//            flag_cnt                   number of set flags
//            redraw                     a map output changed this cycle
//            game_over/game_won         LOST / WON indicators
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl
    import minesweeper_pkg::*;
#(
    parameter int ROWS      = ROWS_DEFAULT,
    parameter int COLS      = COLS_DEFAULT,
    parameter int MAX_FLAGS = 10,
    localparam int N  = ROWS * COLS,
    localparam int IW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mv_up,
    input  logic         mv_down,
    input  logic         mv_left,
    input  logic         mv_right,
    input  logic         step_req,
    input  logic         flag_req,
    input  logic [N-1:0] mine_map,
    output logic [N-1:0] flag_map,
    output logic [N-1:0] step_map,
    output logic [N-1:0] pos_map,
    output logic [6:0]   flag_cnt,
    output logic         redraw,
    output logic         game_over,
    output logic         game_won
);

    state_t        r_state;
    logic [IW-1:0] r_rev_idx;
    logic [IW-1:0] w_cur;
    logic          w_pos_change;
    logic          w_start_ok;
    logic          w_move_en;
    logic          w_map_dirty;

    // start is honoured everywhere except the transient CHECK/REVEAL states.
    assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_PLAY ||
                                   r_state == ST_LOST || r_state == ST_WON);
    // Moves are lowest priority: any step/flag/start pulse in the cycle drops them.
    assign w_move_en   = (r_state == ST_PLAY) && !start && !step_req && !flag_req;
    // Clearing the board only counts as a redraw when something was set.
    assign w_map_dirty = (|flag_map) || (|step_map) || (w_cur != '0);

    cursor_ctrl #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_cursor (
        .clk        (clk),
        .reset      (reset),
        .home       (w_start_ok),
        .move_en    (w_move_en),
        .mv_up      (mv_up),
        .mv_down    (mv_down),
        .mv_left    (mv_left),
        .mv_right   (mv_right),
        .pos_map    (pos_map),
        .cur_idx    (w_cur),
        .pos_change (w_pos_change)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rev_idx <= '0;
            flag_map  <= '0;
            step_map  <= '0;
            flag_cnt  <= '0;
            redraw    <= 1'b0;
            game_over <= 1'b0;
            game_won  <= 1'b0;
        end else begin
            redraw <= 1'b0;
            if (w_start_ok) begin
                r_state   <= ST_PLAY;
                flag_map  <= '0;
                step_map  <= '0;
                flag_cnt  <= '0;
                game_over <= 1'b0;
                game_won  <= 1'b0;
                redraw    <= w_map_dirty;
            end else begin
                unique case (r_state)
                    ST_PLAY: begin
                        if (step_req) begin
                            if (!flag_map[w_cur] && !step_map[w_cur]) begin
                                step_map[w_cur] <= 1'b1;
                                redraw          <= 1'b1;
                                r_state         <= ST_CHECK;
                            end
                        end else if (flag_req) begin
                            if (!step_map[w_cur]) begin
                                if (flag_map[w_cur]) begin
                                    flag_map[w_cur] <= 1'b0;
                                    flag_cnt        <= flag_cnt - 7'd1;
                                    redraw          <= 1'b1;
                                end else if (flag_cnt < 7'(MAX_FLAGS)) begin
                                    flag_map[w_cur] <= 1'b1;
                                    flag_cnt        <= flag_cnt + 7'd1;
                                    redraw          <= 1'b1;
                                end
                            end
                        end else begin
                            redraw <= w_pos_change;
                        end
                    end
                    ST_CHECK: begin
                        // A stepped mine loses even if it would complete the board.
                        if (mine_map[w_cur]) begin
                            r_state   <= ST_REVEAL;
                            r_rev_idx <= '0;
                        end else if (&(step_map | mine_map)) begin
                            r_state  <= ST_WON;
                            game_won <= 1'b1;
                        end else begin
                            r_state <= ST_PLAY;
                        end
                    end
                    ST_REVEAL: begin
                        if (mine_map[r_rev_idx] && !step_map[r_rev_idx]) begin
                            step_map[r_rev_idx] <= 1'b1;
                            redraw              <= 1'b1;
                        end
                        if (r_rev_idx == IW'(N - 1)) begin
                            r_state   <= ST_LOST;
                            game_over <= 1'b1;
                        end else begin
                            r_rev_idx <= r_rev_idx + 1'b1;
                        end
                    end
                    ST_IDLE, ST_LOST, ST_WON: begin
                        r_state <= r_state;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Directed self-checking bench for game_ctrl (8x8 board).
// Config   : honours WRAP_CURSOR_EN for the edge-move expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    localparam logic [6:0] B_START = 7'b1000000;
    localparam logic [6:0] B_STEP  = 7'b0100000;
    localparam logic [6:0] B_FLAG  = 7'b0010000;
    localparam logic [6:0] B_UP    = 7'b0001000;
    localparam logic [6:0] B_DOWN  = 7'b0000100;
    localparam logic [6:0] B_LEFT  = 7'b0000010;
    localparam logic [6:0] B_RIGHT = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, step_req = 1'b0, flag_req = 1'b0;
    logic        mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
    logic [63:0] mine_map = 64'h8000_0000_0000_0001;
    logic [63:0] flag_map, step_map, pos_map;
    logic [6:0]  flag_cnt;
    logic        redraw, game_over, game_won;

    int n_tests = 0;
    int n_fail  = 0;

    game_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mv_up     (mv_up),
        .mv_down   (mv_down),
        .mv_left   (mv_left),
        .mv_right  (mv_right),
        .step_req  (step_req),
        .flag_req  (flag_req),
        .mine_map  (mine_map),
        .flag_map  (flag_map),
        .step_map  (step_map),
        .pos_map   (pos_map),
        .flag_cnt  (flag_cnt),
        .redraw    (redraw),
        .game_over (game_over),
        .game_won  (game_won)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle pulse set, then sample 1 time unit after the edge.
    task automatic press(input logic [6:0] p);
        {start, step_req, flag_req, mv_up, mv_down, mv_left, mv_right} = p;
        @(posedge clk);
        #1;
        {start, step_req, flag_req, mv_up, mv_down, mv_left, mv_right} = '0;
    endtask

    logic [63:0] one;
    logic [63:0] exp_flags;
    int          r;
    int          c;

    initial begin
        one = 64'd1;
        tick(3);
        // ---- 1. reset state and first start
        check("rst_pos",   pos_map, 64'h1);
        check("rst_flag",  flag_map, 64'h0);
        check("rst_step",  step_map, 64'h0);
        check("rst_cnt",   64'(flag_cnt), 64'd0);
        check("rst_over",  64'(game_over), 64'd0);
        reset = 1'b0;
        tick(1);
        press(B_START);
        check("start_pos",    pos_map, 64'h1);
        check("start_redraw", 64'(redraw), 64'd0);
        check("start_cnt",    64'(flag_cnt), 64'd0);

        // ---- 2. left at (0,0)
        press(B_LEFT);
`ifdef WRAP_CURSOR_EN
        check("wrap_pos",    pos_map, one << 7);
        check("wrap_redraw", 64'(redraw), 64'd1);
        tick(1);
        check("wrap_redraw_end", 64'(redraw), 64'd0);
        press(B_RIGHT);
        check("wrap_back", pos_map, 64'h1);
`else
        check("clamp_pos",    pos_map, 64'h1);
        check("clamp_redraw", 64'(redraw), 64'd0);
`endif

        // ---- 3. flag cell 9, blocked step, unflag, move priority
        press(B_DOWN);
        press(B_RIGHT);
        check("pos9", pos_map, one << 9);
        press(B_FLAG);
        check("flag9",        flag_map, one << 9);
        check("flag9_cnt",    64'(flag_cnt), 64'd1);
        check("flag9_redraw", 64'(redraw), 64'd1);
        press(B_STEP);
        check("step_flagged",        step_map, 64'h0);
        check("step_flagged_redraw", 64'(redraw), 64'd0);
        press(B_FLAG);
        check("unflag9",     flag_map, 64'h0);
        check("unflag9_cnt", 64'(flag_cnt), 64'd0);
        press(B_UP | B_DOWN);
        check("prio_up", pos_map, one << 1);
        press(B_LEFT | B_RIGHT);
        check("prio_left", pos_map, 64'h1);

        // ---- 4. step on mine at cell 0 (flag pulse in same cycle dropped)
        press(B_STEP | B_FLAG);
        check("mine_step",  step_map, 64'h1);
        check("mine_noflag", flag_map, 64'h0);
        tick(1);
        check("check_over", 64'(game_over), 64'd0);
        tick(63);
        check("reveal_busy", 64'(game_over), 64'd0);
        tick(1);
        check("lost_over",   64'(game_over), 64'd1);
        check("lost_step",   step_map, 64'h8000_0000_0000_0001);
        check("lost_redraw", 64'(redraw), 64'd1);
        check("lost_won",    64'(game_won), 64'd0);
        press(B_RIGHT);
        check("lost_pos_hold", pos_map, 64'h1);

        // ---- 5. single mine at 0, uncover all other cells (serpentine)
        reset = 1'b1;
        tick(1);
        mine_map = 64'h1;
        reset = 1'b0;
        press(B_START);
        for (int k = 0; k < 64; k++) begin
            r = k / 8;
            c = (r % 2 == 0) ? (k % 8) : (7 - (k % 8));
            if (k > 0) begin
                if (k % 8 == 0)      press(B_DOWN);
                else if (r % 2 == 0) press(B_RIGHT);
                else                 press(B_LEFT);
                press(B_STEP);
                if (k == 63) begin
                    check("last_pos", pos_map, one << (r * 8 + c));
                    check("won_pre", 64'(game_won), 64'd0);
                    tick(1);
                    check("won",      64'(game_won), 64'd1);
                    check("won_step", step_map, ~64'h1);
                    check("won_over", 64'(game_over), 64'd0);
                end else begin
                    tick(1);
                end
            end
        end
        press(B_START);
        check("restart_step",   step_map, 64'h0);
        check("restart_pos",    pos_map, 64'h1);
        check("restart_redraw", 64'(redraw), 64'd1);
        check("restart_won",    64'(game_won), 64'd0);

        // ---- 6. flag limit: cells 1..7, 15, 14, 13, then 12 is refused
        exp_flags = 64'h0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 8)     press(B_DOWN);
            else if (k > 8) press(B_LEFT);
            else            press(B_RIGHT);
            press(B_FLAG);
            exp_flags = exp_flags | (one << ((k <= 7) ? k : (23 - k)));
        end
        check("cnt10",  64'(flag_cnt), 64'd10);
        check("flags10", flag_map, exp_flags);
        press(B_LEFT);
        press(B_FLAG);
        check("flag11_cnt",    64'(flag_cnt), 64'd10);
        check("flag11_map",    flag_map, exp_flags);
        check("flag11_redraw", 64'(redraw), 64'd0);

        // ---- reset in the middle of a reveal sweep
        press(B_UP);
        for (int k = 0; k < 4; k++) press(B_LEFT);
        check("home_pos", pos_map, 64'h1);
        press(B_STEP);
        tick(10);
        reset = 1'b1;
        #1;
        check("mid_rst_flag", flag_map, 64'h0);
        check("mid_rst_step", step_map, 64'h0);
        check("mid_rst_cnt",  64'(flag_cnt), 64'd0);
        check("mid_rst_pos",  pos_map, 64'h1);
        tick(1);
        reset = 1'b0;
        tick(70);
        check("idle_step", step_map, 64'h0);
        check("idle_over", 64'(game_over), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
